mux_sel_sequencer: RTL
======================

// Module: mux_sel_sequencer
// PURPOSE
//  Upstream driver for the 8:1 mux (mux8x1). Accepts a parallel word over a valid/ready handshake.
//  Holds the word on the mux data inputs and steps the mux select through every index.
//  Returns the mux output as a serial bit stream with its own valid/ready handshake.
//  Together with mux8x1 it forms a parallel-to-serial converter.
// PARAMETERS
//  WIDTH      8  word width; equals the number of mux inputs
//  SEL_W      3  select width; must equal clog2(WIDTH)
//  MSB_FIRST  0  0: sel counts 0..WIDTH-1; 1: sel counts WIDTH-1..0
// PORTS
//  clk         in   1      single clock; all state changes on the rising edge
//  rst_n       in   1      synchronous, active-low reset
//  load_valid  in   1      load_data is valid
//  load_ready  out  1      block can accept a word this cycle
//  load_data   in   WIDTH  parallel word to serialise
//  in          out  WIDTH  to mux8x1 in; registered copy of the accepted word
//  sel         out  SEL_W  to mux8x1 sel; registered
//  mux_out     in   1      from mux8x1 out
//  ser_valid   out  1      ser_bit is valid
//  ser_ready   in   1      consumer accepts ser_bit
//  ser_bit     out  1      serial data (mux_out, or the parity bit; see CONFIGURATION)
//  ser_last    out  1      high on the final beat of a frame
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//   - state=IDLE; in=0; sel=start index (0, or WIDTH-1 when MSB_FIRST=1)
//   - ser_valid=0, ser_last=0, load_ready=1
//   - reset overrides any load or beat in progress; a partial frame is dropped with no further beats
//  FSM:
//   - IDLE -> SCAN when load_valid && load_ready. On that edge: in<=load_data, sel<=start index.
//   - SCAN:
//     - ser_valid=1 combinationally; ser_bit=mux_out (a combinational path through mux8x1)
//     - Beat transfers when ser_valid && ser_ready. Then sel steps +1 (or -1 if MSB_FIRST) on the edge.
//     - ser_ready=0: sel and in hold; ser_bit stays stable
//     - Last beat (sel==end index): ser_last=1
//   - SCAN -> IDLE on a last-beat transfer, unless a new load is taken the same cycle (below)
//  load_ready = IDLE || (SCAN && ser_last && ser_ready). This allows back-to-back frames with no bubble:
//   - load on the final-beat edge -> stay SCAN, in<=new word, sel<=start index
//  load_valid while load_ready=0 is ignored; the upstream holds its word.
//  Latency: first bit is valid on the cycle after load acceptance. A frame is WIDTH beats.
//  sel never leaves the range 0..WIDTH-1; no wrap beyond the end index.
//  ser_valid is never deasserted mid-frame except by reset.
// CONFIGURATION
//  MUX_SEQ_PARITY_EN defined:
//   - even parity of load_data is captured at load
//   - frame becomes WIDTH+1 beats; the extra beat follows the end index
//   - on the extra beat: ser_bit=parity, sel holds the end index, ser_last=1 (ser_last stays 0 on the end-index beat)
//   - load_ready/back-to-back rule applies to the parity beat
//  MUX_SEQ_PARITY_EN undefined: WIDTH-beat frames as above; no parity logic is synthesised.
// TESTING
//  1. rst_n=0 for 2 clks mid-frame -> ser_valid=0, sel=0, in=0, load_ready=1 on the following cycle
//  2. load 8'b01100110, ser_ready=1, MSB_FIRST=0:
//     - ser_bit=0,1,1,0,0,1,1,0 on sel=0..7
//     - ser_last only on sel=7
//     - load_ready back to 1 on the sel=7 beat
//  3. Same word, ser_ready toggled 1,0,0,1,...:
//     - sel/ser_bit hold during stall cycles
//     - exactly 8 transfers; no bit lost or duplicated
//  4. load 8'h01 then 8'h22 with load_valid held high:
//     - 16 consecutive beats: 1,0,0,0,0,0,0,0,0,1,0,0,0,1,0,0
//     - no idle cycle between the two frames
//  5. MSB_FIRST=1, load 8'b00000001 -> sel=7..0; ser_bit=0,0,0,0,0,0,0,1
//  6. MUX_SEQ_PARITY_EN, load 8'b01100110 -> 9 beats; 9th ser_bit=0, ser_last=1, sel=7
//     load 8'b00000001 -> 9th ser_bit=1

Source files
------------

// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer: drives the data and select inputs of mux8x1 and returns
// its output as a serial bit stream. Together with the mux, it forms a
// parallel-to-serial converter with valid/ready handshakes on both sides.
// Optional feature macro: MUX_SEQ_PARITY_EN appends an even-parity beat to
// each frame.
module mux_sel_sequencer #(
   parameter int WIDTH     = 8,
   parameter int SEL_W     = 3,
   parameter int MSB_FIRST = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   output logic [WIDTH-1:0] in,
   output logic [SEL_W-1:0] sel,
   input  logic             mux_out,
   output logic             ser_valid,
   input  logic             ser_ready,
   output logic             ser_bit,
   output logic             ser_last
);

   localparam logic [SEL_W-1:0] START_IDX = (MSB_FIRST != 0) ? SEL_W'(WIDTH - 1) : '0;
   localparam logic [SEL_W-1:0] END_IDX   = (MSB_FIRST != 0) ? '0 : SEL_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      PARITY
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] in_q, in_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             load_take;
`ifdef MUX_SEQ_PARITY_EN
   logic             par_q, par_d;
`endif

   assign in  = in_q;
   assign sel = sel_q;

   // State, held word and select registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         in_q    <= '0;
         sel_q   <= START_IDX;
`ifdef MUX_SEQ_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         in_q    <= in_d;
         sel_q   <= sel_d;
`ifdef MUX_SEQ_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   // Serial-side outputs, load handshake and next-state selection.
   always_comb begin
      state_d    = state_q;
      in_d       = in_q;
      sel_d      = sel_q;
`ifdef MUX_SEQ_PARITY_EN
      par_d      = par_q;
`endif
      ser_valid  = 1'b0;
      ser_bit    = 1'b0;
      ser_last   = 1'b0;
      load_ready = 1'b0;
      load_take  = 1'b0;

      case (state_q)
         SCAN: begin
            ser_valid = 1'b1;
            ser_bit   = mux_out;
`ifdef MUX_SEQ_PARITY_EN
            ser_last  = 1'b0;
`else
            ser_last  = (sel_q == END_IDX);
`endif
         end
`ifdef MUX_SEQ_PARITY_EN
         PARITY: begin
            ser_valid = 1'b1;
            ser_bit   = par_q;
            ser_last  = 1'b1;
         end
`endif
         default: begin
         end
      endcase

      // A new word may be taken while the final beat of a frame leaves,
      // so back-to-back frames have no idle cycle between them.
      load_ready = (state_q == IDLE) || (ser_last && ser_ready);
      load_take  = load_valid && load_ready;

      if (ser_valid && ser_ready) begin
         if (state_q == SCAN) begin
            if (sel_q == END_IDX) begin
`ifdef MUX_SEQ_PARITY_EN
               state_d = PARITY;
`else
               state_d = IDLE;
`endif
            end else if (MSB_FIRST != 0) begin
               sel_d = sel_q - SEL_W'(1);
            end else begin
               sel_d = sel_q + SEL_W'(1);
            end
         end else begin
            state_d = IDLE;
         end
      end

      if (load_take) begin
         state_d = SCAN;
         in_d    = load_data;
         sel_d   = START_IDX;
`ifdef MUX_SEQ_PARITY_EN
         par_d   = ^load_data;
`endif
      end
   end

endmodule
